dram_ctrl: RTL and testbench

Load/store initiator for the single-port-write / single-port-read data RAM (`dram`). Accepts one CPU data-memory request at a time and drives the RAM's write and read ports. Stores are translated into byte-strobed writes; loads are returned aligned and sign- or zero-extended. Sits between the core's memory stage and `dram`, and flags misaligned or out-of-range accesses instead of touching the RAM.

---
 rtl/dram_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_dram_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_ctrl.sv
// Load/store initiator for the data RAM: turns one CPU request at a time into
// byte-strobed RAM writes or aligned, extended RAM reads, rejecting bad accesses.
package configure;
    localparam int dram_depth = 10;
endpackage

module dram_ctrl
    import configure::*;
#(
    parameter logic [31:0] DRAM_BASE = 32'h0010_0000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_mem_valid,
    input  logic                  i_mem_wren,
    input  logic [31:0]           i_mem_addr,
    input  logic [31:0]           i_mem_wdata,
    input  logic [1:0]            i_mem_size,
    input  logic                  i_mem_unsigned,
    output logic                  o_mem_ready,
    output logic [31:0]           o_mem_rdata,
    output logic                  o_mem_error,
    output logic                  o_dram_wen,
    output logic [dram_depth-1:0] o_dram_waddr,
    output logic [dram_depth-1:0] o_dram_raddr,
    output logic [31:0]           o_dram_wdata,
    output logic [3:0]            o_dram_wstrb,
    input  logic [31:0]           i_dram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_LOAD,
        S_RESP,
        S_ERR
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic                  r_mem_ready;
    logic [31:0]           r_mem_rdata;
    logic                  r_mem_error;
    logic                  r_dram_wen;
    logic [dram_depth-1:0] r_dram_waddr;
    logic [dram_depth-1:0] r_dram_raddr;
    logic [31:0]           r_dram_wdata;
    logic [3:0]            r_dram_wstrb;

    logic [1:0] r_off;
    logic [1:0] r_size;
    logic       r_unsigned;

    logic [1:0]            w_off;
    logic [dram_depth-1:0] w_word_addr;
    logic                  w_in_range;
    logic                  w_err;
    logic [3:0]            w_wstrb;
    logic [31:0]           w_wdata;
    logic [31:0]           w_shifted;
    logic [31:0]           w_load_data;

    assign w_off       = i_mem_addr[1:0];
    assign w_word_addr = i_mem_addr[dram_depth+1:2];
    assign w_in_range  = (i_mem_addr[31:dram_depth+2] == DRAM_BASE[31:dram_depth+2]);

    always_comb begin
        w_err = 1'b0;
        case (i_mem_size)
            2'd0:    w_err = 1'b0;
            2'd1:    w_err = w_off[0];
            2'd2:    w_err = (w_off != 2'd0);
            default: w_err = 1'b1;
        endcase
        if (!w_in_range) begin
            w_err = 1'b1;
        end
    end

    // Data is replicated across lanes so the strobes alone select the target bytes.
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = i_mem_wdata;
        case (i_mem_size)
            2'd0: begin
                w_wstrb = 4'b0001 << w_off;
                w_wdata = {4{i_mem_wdata[7:0]}};
            end
            2'd1: begin
                w_wstrb = 4'b0011 << w_off;
                w_wdata = {2{i_mem_wdata[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = i_mem_wdata;
            end
        endcase
    end

    assign w_shifted = i_dram_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_size)
            2'd0:    w_load_data = {{24{w_shifted[7] & ~r_unsigned}}, w_shifted[7:0]};
            2'd1:    w_load_data = {{16{w_shifted[15] & ~r_unsigned}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_mem_valid) begin
                    if (w_err) begin
                        w_next_state = S_ERR;
                    end else if (i_mem_wren) begin
                        w_next_state = S_WRITE;
                    end else begin
                        w_next_state = S_READ;
                    end
                end
            end
            S_READ:  w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_RESP;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs are computed one state ahead so every port comes straight from a flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_mem_ready  <= 1'b0;
            r_mem_rdata  <= '0;
            r_mem_error  <= 1'b0;
            r_dram_wen   <= 1'b0;
            r_dram_waddr <= '0;
            r_dram_raddr <= '0;
            r_dram_wdata <= '0;
            r_dram_wstrb <= '0;
            r_off        <= '0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_mem_ready  <= 1'b0;
            r_mem_rdata  <= '0;
            r_mem_error  <= 1'b0;
            r_dram_wen   <= 1'b0;
            r_dram_wstrb <= '0;
            case (r_state)
                S_IDLE: begin
                    if (i_mem_valid) begin
                        r_off      <= w_off;
                        r_size     <= i_mem_size;
                        r_unsigned <= i_mem_unsigned;
                        if (w_err) begin
                            r_mem_ready <= 1'b1;
                            r_mem_error <= 1'b1;
                        end else if (i_mem_wren) begin
                            r_mem_ready  <= 1'b1;
                            r_dram_wen   <= 1'b1;
                            r_dram_waddr <= w_word_addr;
                            r_dram_wstrb <= w_wstrb;
                            r_dram_wdata <= w_wdata;
                        end else begin
                            r_dram_raddr <= w_word_addr;
                        end
                    end
                end
                S_LOAD: begin
                    r_mem_ready <= 1'b1;
                    r_mem_rdata <= w_load_data;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_mem_ready  = r_mem_ready;
    assign o_mem_rdata  = r_mem_rdata;
    assign o_mem_error  = r_mem_error;
    assign o_dram_wen   = r_dram_wen;
    assign o_dram_waddr = r_dram_waddr;
    assign o_dram_raddr = r_dram_raddr;
    assign o_dram_wdata = r_dram_wdata;
    assign o_dram_wstrb = r_dram_wstrb;

endmodule

// File: tb/tb_dram_ctrl.sv
// Testbench for dram_ctrl: a behavioural RAM plus a byte-array reference model
// of memory contents, driven by directed scenarios and random request streams.
module tb_dram_ctrl;
    import configure::*;

    localparam logic [31:0] BASE = 32'h0010_0000;
    localparam int RAM_BYTES = 4 * (1 << dram_depth);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  memValid;
    logic                  memWren;
    logic [31:0]           memAddr;
    logic [31:0]           memWdata;
    logic [1:0]            memSize;
    logic                  memUnsigned;
    logic                  memReady;
    logic [31:0]           memRdata;
    logic                  memError;
    logic                  dramWen;
    logic [dram_depth-1:0] dramWaddr;
    logic [dram_depth-1:0] dramRaddr;
    logic [31:0]           dramWdata;
    logic [3:0]            dramWstrb;
    logic [31:0]           dramRdata;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ram [0:(1<<dram_depth)-1];
    logic [7:0]  refBytes [0:RAM_BYTES-1];

    typedef struct {
        int                    lat;
        logic [31:0]           rdata;
        logic                  err;
        logic                  sawWen;
        logic [3:0]            wstrb;
        logic [31:0]           wdata;
        logic [dram_depth-1:0] waddr;
        logic                  readyAfter;
    } obs_t;

    dram_ctrl #(.DRAM_BASE(BASE)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_mem_valid(memValid),
        .i_mem_wren(memWren),
        .i_mem_addr(memAddr),
        .i_mem_wdata(memWdata),
        .i_mem_size(memSize),
        .i_mem_unsigned(memUnsigned),
        .o_mem_ready(memReady),
        .o_mem_rdata(memRdata),
        .o_mem_error(memError),
        .o_dram_wen(dramWen),
        .o_dram_waddr(dramWaddr),
        .o_dram_raddr(dramRaddr),
        .o_dram_wdata(dramWdata),
        .o_dram_wstrb(dramWstrb),
        .i_dram_rdata(dramRdata)
    );

    always #5 clk = ~clk;

    // Environment RAM: byte-strobed write port, registered read port.
    always @(posedge clk) begin
        if (dramWen) begin
            for (int j = 0; j < 4; j++) begin
                if (dramWstrb[j]) ram[dramWaddr][8*j +: 8] <= dramWdata[8*j +: 8];
            end
        end
        dramRdata <= ram[dramRaddr];
    end

    function automatic int nBytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    function automatic logic refErr(input logic [31:0] a, input logic [1:0] s);
        if (s == 2'd3) return 1'b1;
        if ((a % nBytes(s)) != 0) return 1'b1;
        if (a < BASE || a >= BASE + RAM_BYTES) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [1:0] s, input logic u);
        logic [31:0] v = 0;
        int n = nBytes(s);
        for (int i = 0; i < n; i++) v = v | (32'(refBytes[a - BASE + i]) << (8 * i));
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic logic [3:0] refStrb(input logic [31:0] a, input logic [1:0] s);
        logic [3:0] m = 0;
        for (int i = 0; i < nBytes(s); i++) m[(a % 4) + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] refWdata(input logic [31:0] d, input logic [1:0] s);
        logic [31:0] v = 0;
        for (int j = 0; j < 4; j++) v[8*j +: 8] = d[8*(j % nBytes(s)) +: 8];
        return v;
    endfunction

    task automatic refStore(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        for (int i = 0; i < nBytes(s); i++) refBytes[a - BASE + i] = d[8*i +: 8];
    endtask

    // Presents one request at the current negedge and follows it to completion.
    task automatic doReq(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic u, output obs_t o);
        o.lat = 0; o.rdata = 0; o.err = 0; o.sawWen = 0;
        o.wstrb = 0; o.wdata = 0; o.waddr = 0; o.readyAfter = 0;
        memValid = 1'b1; memWren = w; memAddr = a; memWdata = d; memSize = s; memUnsigned = u;
        do begin
            @(negedge clk);
            o.lat++;
            if (dramWen) begin
                o.sawWen = 1'b1; o.wstrb = dramWstrb; o.wdata = dramWdata; o.waddr = dramWaddr;
            end
        end while (!memReady && o.lat < 20);
        o.rdata = memRdata;
        o.err = memError;
        memValid = 1'b0;
        @(negedge clk);
        o.readyAfter = memReady;
        if (dramWen) o.sawWen = 1'b1;
        if (o.lat < 20 && w && !refErr(a, s)) refStore(a, d, s);
    endtask

    task automatic test_reset();
        obs_t o;
        memValid = 1'b1; memWren = 1'b1; memAddr = BASE + 32'h40; memWdata = 32'h1234_5678;
        memSize = 2'd2; memUnsigned = 1'b0; rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if ({memReady, memRdata, memError, dramWen, dramWaddr, dramRaddr, dramWdata, dramWstrb} !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs cycle %0d: ready=%b rdata=%h err=%b wen=%b waddr=%h raddr=%h wdata=%h wstrb=%h, want all 0",
                         c, memReady, memRdata, memError, dramWen, dramWaddr, dramRaddr, dramWdata, dramWstrb);
            end
        end
        rst = 1'b0;
        doReq(1'b1, BASE + 32'h40, 32'h1234_5678, 2'd2, 1'b0, o);
        vectors++; if (o.lat !== 1) begin miscompares++; $display("[TB] FAIL post_reset_store_lat got %0d want 1", o.lat); end
        vectors++; if (o.sawWen !== 1'b1 || o.waddr !== 10'h10) begin miscompares++; $display("[TB] FAIL post_reset_store_wen got wen=%b waddr=%h want 1/010", o.sawWen, o.waddr); end
    endtask

    task automatic test_store_word();
        obs_t o;
        doReq(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, o);
        vectors++; if (o.lat !== 1) begin miscompares++; $display("[TB] FAIL sw_lat got %0d want 1", o.lat); end
        vectors++; if (o.sawWen !== 1'b1) begin miscompares++; $display("[TB] FAIL sw_wen got %b want 1", o.sawWen); end
        vectors++; if (o.waddr !== 10'd4) begin miscompares++; $display("[TB] FAIL sw_waddr got %0d want 4", o.waddr); end
        vectors++; if (o.wstrb !== 4'hF) begin miscompares++; $display("[TB] FAIL sw_wstrb got %h want f", o.wstrb); end
        vectors++; if (o.wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL sw_wdata got %h want deadbeef", o.wdata); end
        vectors++; if (o.err !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_err got %b want 0", o.err); end
        vectors++; if (o.readyAfter !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_ready_pulse got %b want 0", o.readyAfter); end
    endtask

    task automatic test_byte_lanes();
        obs_t o;
        doReq(1'b1, BASE + 32'h13, 32'h0000_00A5, 2'd0, 1'b0, o);
        vectors++; if (o.wstrb !== 4'b1000) begin miscompares++; $display("[TB] FAIL sb_wstrb got %b want 1000", o.wstrb); end
        vectors++; if (o.wdata !== 32'hA5A5_A5A5) begin miscompares++; $display("[TB] FAIL sb_wdata got %h want a5a5a5a5", o.wdata); end
        doReq(1'b0, BASE + 32'h13, 32'h0, 2'd0, 1'b0, o);
        vectors++; if (o.lat !== 3) begin miscompares++; $display("[TB] FAIL lb_lat got %0d want 3", o.lat); end
        vectors++; if (o.rdata !== 32'hFFFF_FFA5) begin miscompares++; $display("[TB] FAIL lb_signed got %h want ffffffa5", o.rdata); end
        vectors++; if (o.readyAfter !== 1'b0 || o.sawWen !== 1'b0) begin miscompares++; $display("[TB] FAIL lb_pulse got ready_after=%b wen=%b want 0/0", o.readyAfter, o.sawWen); end
        doReq(1'b0, BASE + 32'h13, 32'h0, 2'd0, 1'b1, o);
        vectors++; if (o.rdata !== 32'h0000_00A5) begin miscompares++; $display("[TB] FAIL lbu got %h want 000000a5", o.rdata); end
    endtask

    task automatic test_half_loads();
        obs_t o;
        doReq(1'b1, BASE + 32'h20, 32'h8001_1234, 2'd2, 1'b0, o);
        doReq(1'b0, BASE + 32'h22, 32'h0, 2'd1, 1'b0, o);
        vectors++; if (o.rdata !== 32'hFFFF_8001) begin miscompares++; $display("[TB] FAIL lh_signed got %h want ffff8001", o.rdata); end
        doReq(1'b0, BASE + 32'h20, 32'h0, 2'd1, 1'b1, o);
        vectors++; if (o.rdata !== 32'h0000_1234) begin miscompares++; $display("[TB] FAIL lhu got %h want 00001234", o.rdata); end
    endtask

    task automatic test_errors();
        obs_t o;
        logic        w [3]   = '{1'b1, 1'b0, 1'b1};
        logic [31:0] a [3]   = '{BASE + 32'h2, 32'h0020_0000, BASE};
        logic [1:0]  s [3]   = '{2'd2, 2'd2, 2'd3};
        for (int k = 0; k < 3; k++) begin
            doReq(w[k], a[k], 32'hFFFF_FFFF, s[k], 1'b0, o);
            vectors++; if (o.err !== 1'b1 || o.lat !== 1) begin miscompares++; $display("[TB] FAIL err_%0d got err=%b lat=%0d want 1/1", k, o.err, o.lat); end
            vectors++; if (o.sawWen !== 1'b0) begin miscompares++; $display("[TB] FAIL err_%0d_wen got %b want 0", k, o.sawWen); end
            vectors++; if (o.rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL err_%0d_rdata got %h want 0", k, o.rdata); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        doReq(1'b1, BASE + 32'h30, 32'hCAFE_F00D, 2'd2, 1'b0, o);
        doReq(1'b0, BASE + 32'h30, 32'h0, 2'd2, 1'b0, o);
        vectors++; if (o.rdata !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL b2b_word got %h want cafef00d", o.rdata); end
        doReq(1'b1, BASE + 32'h31, 32'h0000_0077, 2'd0, 1'b0, o);
        doReq(1'b0, BASE + 32'h30, 32'h0, 2'd2, 1'b0, o);
        vectors++; if (o.rdata !== 32'hCAFE_770D) begin miscompares++; $display("[TB] FAIL b2b_byte got %h want cafe770d", o.rdata); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int readies = 0;
        doReq(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, o);
        memValid = 1'b1; memWren = 1'b0; memAddr = BASE + 32'h10; memSize = 2'd2; memUnsigned = 1'b0;
        @(negedge clk);
        rst = 1'b1; memValid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({memReady, memRdata, memError, dramWen, dramWaddr, dramRaddr, dramWdata, dramWstrb} !== '0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs: ready=%b rdata=%h err=%b wen=%b waddr=%h raddr=%h wdata=%h wstrb=%h, want all 0",
                     memReady, memRdata, memError, dramWen, dramWaddr, dramRaddr, dramWdata, dramWstrb);
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (memReady) readies++;
        end
        vectors++; if (readies !== 0) begin miscompares++; $display("[TB] FAIL midreset_ready got %0d pulses want 0", readies); end
        doReq(1'b0, BASE + 32'h10, 32'h0, 2'd2, 1'b0, o);
        vectors++; if (o.rdata !== 32'hDEAD_BEEF || o.lat !== 3) begin miscompares++; $display("[TB] FAIL midreset_reload got %h lat=%0d want deadbeef lat=3", o.rdata, o.lat); end
    endtask

    task automatic test_random();
        obs_t o;
        for (int k = 0; k < 120; k++) begin
            logic        w  = 1'($urandom % 2);
            logic        u  = 1'($urandom % 2);
            logic [1:0]  s  = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            logic [31:0] a  = ($urandom % 10 == 0) ? $urandom : BASE + $urandom_range(0, 63);
            logic [31:0] d  = $urandom;
            logic        e  = refErr(a, s);
            logic [31:0] ld = e ? 32'h0 : refLoad(a, s, u);
            int          el = (e || w) ? 1 : 3;
            doReq(w, a, d, s, u, o);
            vectors++; if (o.lat !== el || o.err !== e) begin miscompares++; $display("[TB] FAIL rnd%0d_lat_err got lat=%0d err=%b want %0d/%b", k, o.lat, o.err, el, e); end
            vectors++; if (o.sawWen !== (w && !e)) begin miscompares++; $display("[TB] FAIL rnd%0d_wen got %b want %b", k, o.sawWen, w && !e); end
            vectors++; if (o.rdata !== ((w || e) ? 32'h0 : ld)) begin miscompares++; $display("[TB] FAIL rnd%0d_rdata got %h want %h", k, o.rdata, (w || e) ? 32'h0 : ld); end
            vectors++; if (o.readyAfter !== 1'b0) begin miscompares++; $display("[TB] FAIL rnd%0d_pulse got %b want 0", k, o.readyAfter); end
            if (w && !e) begin
                vectors++;
                if (o.wstrb !== refStrb(a, s) || o.wdata !== refWdata(d, s) || 32'(o.waddr) !== (a - BASE) / 4) begin
                    miscompares++;
                    $display("[TB] FAIL rnd%0d_store got strb=%b data=%h waddr=%0d want %b/%h/%0d",
                             k, o.wstrb, o.wdata, o.waddr, refStrb(a, s), refWdata(d, s), (a - BASE) / 4);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << dram_depth); i++) ram[i] = 32'h0;
        for (int i = 0; i < RAM_BYTES; i++) refBytes[i] = 8'h0;
        rst = 1'b1; memValid = 1'b0; memWren = 1'b0; memAddr = 0; memWdata = 0;
        memSize = 0; memUnsigned = 0;
        repeat (2) @(negedge clk);
        test_reset();
        test_store_word();
        test_byte_lanes();
        test_half_loads();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
